// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ==================================================================
// sram_arbiter_pkg : shared widths and state/owner types, SRAM arbiter
// Rev 1.0
// ==================================================================
package sram_arbiter_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int ADDR_WIDTH   = 32;
  localparam int NUM_OF_BYTES = DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  // The values double as bit indices into the arbiter's request/grant vectors.
  typedef enum logic [0:0] {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ==================================================================
// sram_arbiter_if : requester and SRAM-side signal bundle
// Rev 1.0
// ==================================================================
interface sram_arbiter_if #(
  parameter int DATA_WIDTH = sram_arbiter_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = sram_arbiter_pkg::ADDR_WIDTH
);

  localparam int NUM_OF_BYTES = DATA_WIDTH / 8;

  logic                    if_req_valid;
  logic                    if_req_ready;
  logic [ADDR_WIDTH-1:0]   if_req_addr;
  logic                    if_rsp_valid;
  logic [DATA_WIDTH-1:0]   if_rsp_data;
  logic                    if_rsp_err;

  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic                    mem_req_we;
  logic [ADDR_WIDTH-1:0]   mem_req_addr;
  logic [DATA_WIDTH-1:0]   mem_req_wdata;
  logic [NUM_OF_BYTES-1:0] mem_req_wmask;
  logic                    mem_rsp_valid;
  logic [DATA_WIDTH-1:0]   mem_rsp_data;
  logic                    mem_rsp_err;

  logic                    sram_rd_en;
  logic [ADDR_WIDTH-1:0]   sram_rd_addr;
  logic                    sram_rd_valid;
  logic [DATA_WIDTH-1:0]   sram_rd_data;
  logic                    sram_wr_en;
  logic [ADDR_WIDTH-1:0]   sram_wr_addr;
  logic [DATA_WIDTH-1:0]   sram_wr_data;
  logic [NUM_OF_BYTES-1:0] sram_w_mask;

  // Arbiter view
  modport slave (
    input  if_req_valid, if_req_addr,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
    input  sram_rd_valid, sram_rd_data,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    output sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data, sram_w_mask
  );

  // Requesters plus SRAM view
  modport master (
    output if_req_valid, if_req_addr,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
    output sram_rd_valid, sram_rd_data,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    input  sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data, sram_w_mask
  );

endinterface
`default_nettype wire

// File: rtl/sram_arbiter_rr_arb2.sv
`default_nettype none
// ==================================================================
// rr_arb2 : two-way round-robin arbiter, one-hot grant, pointer flips on grant
// Rev 1.0
// ==================================================================
module rr_arb2
  import sram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  owner_e r_prio;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[OWN_IF] && req[OWN_MEM]) begin
        gnt[r_prio] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

  // Priority moves to whichever side was not just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= OWN_MEM;
    end else if (gnt[OWN_IF]) begin
      r_prio <= OWN_MEM;
    end else if (gnt[OWN_MEM]) begin
      r_prio <= OWN_IF;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ==================================================================
// sram_arbiter : shares one SRAM port between instruction fetch and data memory
// Rev 1.0
// ==================================================================
module sram_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  sram_arbiter_if.slave bus
);

  import sram_arbiter_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e                r_state;
  owner_e                r_owner;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_arb_en;
  logic [1:0]            w_req;
  logic [1:0]            w_gnt;
  logic                  w_gnt_any;
  logic                  w_is_write;
  owner_e                w_gnt_owner;
  logic [ADDR_WIDTH-1:0] w_gnt_addr;
  logic                  w_timeout;
  logic [DATA_WIDTH-1:0] w_rsp_data;

  assign w_arb_en = (r_state == IDLE);
  assign w_req    = {bus.mem_req_valid, bus.if_req_valid};

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_arb_en),
    .req   (w_req),
    .gnt   (w_gnt)
  );

  assign bus.if_req_ready  = w_gnt[OWN_IF];
  assign bus.mem_req_ready = w_gnt[OWN_MEM];

  assign w_gnt_any   = |w_gnt;
  assign w_is_write  = w_gnt[OWN_MEM] & bus.mem_req_we;
  assign w_gnt_owner = w_gnt[OWN_MEM] ? OWN_MEM : OWN_IF;
  assign w_gnt_addr  = w_gnt[OWN_MEM] ? bus.mem_req_addr : bus.if_req_addr;

  // Real data wins a tie with the timeout; a timed-out response carries zero data.
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_rsp_data = bus.sram_rd_valid ? bus.sram_rd_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= IDLE;
      r_owner           <= OWN_IF;
      r_cnt             <= '0;
      bus.sram_rd_en    <= 1'b0;
      bus.sram_rd_addr  <= '0;
      bus.sram_wr_en    <= 1'b0;
      bus.sram_wr_addr  <= '0;
      bus.sram_wr_data  <= '0;
      bus.sram_w_mask   <= '0;
      bus.if_rsp_valid  <= 1'b0;
      bus.if_rsp_data   <= '0;
      bus.if_rsp_err    <= 1'b0;
      bus.mem_rsp_valid <= 1'b0;
      bus.mem_rsp_data  <= '0;
      bus.mem_rsp_err   <= 1'b0;
    end else begin
      bus.sram_rd_en    <= 1'b0;
      bus.sram_wr_en    <= 1'b0;
      bus.if_rsp_valid  <= 1'b0;
      bus.mem_rsp_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_gnt_any) begin
            if (w_is_write) begin
              // Writes never leave IDLE, so they can stream every cycle.
              bus.sram_wr_en   <= 1'b1;
              bus.sram_wr_addr <= bus.mem_req_addr;
              bus.sram_wr_data <= bus.mem_req_wdata;
              bus.sram_w_mask  <= bus.mem_req_wmask;
            end else begin
              bus.sram_rd_en   <= 1'b1;
              bus.sram_rd_addr <= w_gnt_addr;
              r_owner          <= w_gnt_owner;
              r_cnt            <= '0;
              r_state          <= RD_WAIT;
            end
          end
        end

        RD_WAIT: begin
          if (bus.sram_rd_valid || w_timeout) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            if (r_owner == OWN_IF) begin
              bus.if_rsp_valid  <= 1'b1;
              bus.if_rsp_data   <= w_rsp_data;
              bus.if_rsp_err    <= ~bus.sram_rd_valid;
            end else begin
              bus.mem_rsp_valid <= 1'b1;
              bus.mem_rsp_data  <= w_rsp_data;
              bus.mem_rsp_err   <= ~bus.sram_rd_valid;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// Self-checking bench for sram_arbiter: directed scenarios, then randomized
// traffic against a transaction-level model with its own SRAM.
module tb_sram_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 255;
  localparam int RAND_CYCLES = 400;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.if_req_valid  = 1'b0;
    bus.if_req_addr   = '0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_we    = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_req_wdata = '0;
    bus.mem_req_wmask = '0;
    bus.sram_rd_valid = 1'b0;
    bus.sram_rd_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_if_ready"},  bus.if_req_ready,  0);
    chk({tag, "_mem_ready"}, bus.mem_req_ready, 0);
    chk({tag, "_if_rsp"},    bus.if_rsp_valid,  0);
    chk({tag, "_if_data"},   bus.if_rsp_data,   0);
    chk({tag, "_if_err"},    bus.if_rsp_err,    0);
    chk({tag, "_mem_rsp"},   bus.mem_rsp_valid, 0);
    chk({tag, "_mem_data"},  bus.mem_rsp_data,  0);
    chk({tag, "_mem_err"},   bus.mem_rsp_err,   0);
    chk({tag, "_rd_en"},     bus.sram_rd_en,    0);
    chk({tag, "_rd_addr"},   bus.sram_rd_addr,  0);
    chk({tag, "_wr_en"},     bus.sram_wr_en,    0);
    chk({tag, "_wr_addr"},   bus.sram_wr_addr,  0);
    chk({tag, "_wr_data"},   bus.sram_wr_data,  0);
    chk({tag, "_w_mask"},    bus.sram_w_mask,   0);
  endtask

  function automatic logic [31:0] apply_mask(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  logic [31:0] wa [3] = '{32'h10, 32'h14, 32'h18};
  logic [31:0] wd [3] = '{32'hA1B2C3D4, 32'h55667788, 32'h99AABBCC};
  logic [3:0]  wm [3] = '{4'hF, 4'h3, 4'h8};

  // Random-phase model state
  logic [31:0] ref_mem  [8];
  logic [31:0] sram_mem [8];
  bit          m_busy, m_last_mem, g_if, g_mem, acc_if, acc_mem;
  bit          exp_wr, exp_rd, exp_rsp_if, exp_rsp_mem, rd_owner_mem;
  logic [31:0] exp_wr_addr, exp_wr_data, exp_rd_addr, exp_rsp_data, rd_exp_data;
  logic [3:0]  exp_wr_mask;
  int          sram_cd;
  logic [2:0]  sram_idx;
  int          n;
  bit          is_mem, prev_mem;

  initial begin
    // ---------------- reset state ----------------
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    sample();
    chk_zero("rst");
    edge_drive();
    rst_n = 1'b1;

    // ---------------- arbitration: both reads valid, MEM first ----------------
    bus.if_req_valid  = 1'b1;
    bus.if_req_addr   = 32'h200;
    bus.mem_req_valid = 1'b1;
    bus.mem_req_we    = 1'b0;
    bus.mem_req_addr  = 32'h300;
    prev_mem = 1'b0;
    for (int k = 0; k < 4; k++) begin
      is_mem = (k % 2 == 0);
      sample();
      chk("arb_mem_ready", bus.mem_req_ready, is_mem);
      chk("arb_if_ready",  bus.if_req_ready,  !is_mem);
      if (k > 0) begin
        chk("arb_rsp_mem",  bus.mem_rsp_valid, prev_mem);
        chk("arb_rsp_if",   bus.if_rsp_valid,  !prev_mem);
        chk("arb_rsp_data", prev_mem ? bus.mem_rsp_data : bus.if_rsp_data, 32'hA0000000 | (k - 1));
      end
      edge_drive();
      sample();
      chk("arb_rd_en",   bus.sram_rd_en, 1);
      chk("arb_rd_addr", bus.sram_rd_addr, is_mem ? 32'h300 : 32'h200);
      chk("arb_busy_ready", bus.if_req_ready | bus.mem_req_ready, 0);
      edge_drive();
      bus.sram_rd_valid = 1'b1;
      bus.sram_rd_data  = 32'hA0000000 | k;
      sample();
      edge_drive();
      bus.sram_rd_valid = 1'b0;
      if (k == 3) begin
        bus.if_req_valid  = 1'b0;
        bus.mem_req_valid = 1'b0;
      end
      prev_mem = is_mem;
    end
    sample();
    chk("arb_last_rsp_if",  bus.if_rsp_valid, 1);
    chk("arb_last_rsp_dat", bus.if_rsp_data, 32'hA0000003);
    chk("arb_last_no_gnt",  bus.if_req_ready | bus.mem_req_ready, 0);
    edge_drive();

    // ---------------- IF read 0x100, rd_valid 3 cycles after rd_en ----------------
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h100;
    sample();
    chk("b_if_ready",  bus.if_req_ready, 1);
    chk("b_mem_ready", bus.mem_req_ready, 0);
    edge_drive();
    bus.if_req_valid = 1'b0;
    sample();
    chk("b_rd_en",      bus.sram_rd_en, 1);
    chk("b_rd_addr",    bus.sram_rd_addr, 32'h100);
    chk("b_ready_wait", bus.if_req_ready, 0);
    edge_drive();
    sample();
    chk("b_rd_en_pulse", bus.sram_rd_en, 0);
    edge_drive();
    sample();
    edge_drive();
    bus.sram_rd_valid = 1'b1;
    bus.sram_rd_data  = 32'hDEADBEEF;
    sample();
    chk("b_no_early_rsp", bus.if_rsp_valid, 0);
    edge_drive();
    bus.sram_rd_valid = 1'b0;
    sample();
    chk("b_rsp_valid", bus.if_rsp_valid, 1);
    chk("b_rsp_data",  bus.if_rsp_data, 32'hDEADBEEF);
    chk("b_rsp_err",   bus.if_rsp_err, 0);
    chk("b_mem_rsp",   bus.mem_rsp_valid, 0);
    edge_drive();
    sample();
    chk("b_rsp_pulse", bus.if_rsp_valid, 0);
    chk("b_rsp_hold",  bus.if_rsp_data, 32'hDEADBEEF);
    edge_drive();

    // ---------------- back-to-back MEM writes ----------------
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we    = 1'b1;
        bus.mem_req_addr  = wa[i];
        bus.mem_req_wdata = wd[i];
        bus.mem_req_wmask = wm[i];
      end else begin
        bus.mem_req_valid = 1'b0;
      end
      sample();
      if (i < 3) chk("c_ready", bus.mem_req_ready, 1);
      if (i > 0) begin
        chk("c_wr_en",   bus.sram_wr_en, 1);
        chk("c_wr_addr", bus.sram_wr_addr, wa[i-1]);
        chk("c_wr_data", bus.sram_wr_data, wd[i-1]);
        chk("c_w_mask",  bus.sram_w_mask, wm[i-1]);
      end
      chk("c_no_rsp", bus.mem_rsp_valid, 0);
      edge_drive();
    end
    sample();
    chk("c_wr_end",    bus.sram_wr_en, 0);
    chk("c_no_rsp_end", bus.mem_rsp_valid, 0);
    edge_drive();

    // ---------------- MEM read timeout, then stray rd_valid ----------------
    bus.mem_req_valid = 1'b1;
    bus.mem_req_we    = 1'b0;
    bus.mem_req_addr  = 32'h40;
    sample();
    chk("e_ready", bus.mem_req_ready, 1);
    edge_drive();
    bus.mem_req_valid = 1'b0;
    sample();
    chk("e_rd_en", bus.sram_rd_en, 1);
    n = 0;
    while (!bus.mem_rsp_valid && n < 2 * TO) begin
      edge_drive();
      sample();
      n++;
    end
    chk("e_timeout_cycles", n, TO);
    chk("e_err",    bus.mem_rsp_err, 1);
    chk("e_data",   bus.mem_rsp_data, 0);
    chk("e_if_rsp", bus.if_rsp_valid, 0);
    edge_drive();
    bus.sram_rd_valid = 1'b1;
    bus.sram_rd_data  = 32'h55;
    sample();
    chk("e_stray_rsp", bus.mem_rsp_valid, 0);
    edge_drive();
    bus.sram_rd_valid = 1'b0;
    sample();
    chk("e_stray_rsp2", bus.mem_rsp_valid | bus.if_rsp_valid, 0);
    edge_drive();

    // ---------------- reset during RD_WAIT ----------------
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h180;
    sample();
    chk("f_ready", bus.if_req_ready, 1);
    edge_drive();
    bus.if_req_valid = 1'b0;
    sample();
    chk("f_rd_en", bus.sram_rd_en, 1);
    edge_drive();
    sample();
    edge_drive();
    rst_n = 1'b0;
    sample();
    chk_zero("f_rst");
    edge_drive();
    bus.sram_rd_valid = 1'b1;
    bus.sram_rd_data  = 32'h77;
    sample();
    edge_drive();
    rst_n = 1'b1;
    sample();
    chk("f_no_rsp", bus.if_rsp_valid, 0);
    edge_drive();
    bus.sram_rd_valid = 1'b0;
    sample();
    chk("f_no_rsp2", bus.if_rsp_valid | bus.mem_rsp_valid, 0);
    edge_drive();
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h104;
    sample();
    chk("f2_ready", bus.if_req_ready, 1);
    edge_drive();
    bus.if_req_valid = 1'b0;
    sample();
    chk("f2_rd_en",   bus.sram_rd_en, 1);
    chk("f2_rd_addr", bus.sram_rd_addr, 32'h104);
    edge_drive();
    sample();
    edge_drive();
    bus.sram_rd_valid = 1'b1;
    bus.sram_rd_data  = 32'h12345678;
    sample();
    edge_drive();
    bus.sram_rd_valid = 1'b0;
    sample();
    chk("f2_rsp_valid", bus.if_rsp_valid, 1);
    chk("f2_rsp_data",  bus.if_rsp_data, 32'h12345678);
    chk("f2_rsp_err",   bus.if_rsp_err, 0);
    edge_drive();

    // ---------------- MEM write blocked behind IF read ----------------
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h1C0;
    sample();
    chk("g_if_ready", bus.if_req_ready, 1);
    edge_drive();
    bus.if_req_valid  = 1'b0;
    bus.mem_req_valid = 1'b1;
    bus.mem_req_we    = 1'b1;
    bus.mem_req_addr  = 32'h24;
    bus.mem_req_wdata = 32'hCAFEF00D;
    bus.mem_req_wmask = 4'h6;
    sample();
    chk("g_rd_en", bus.sram_rd_en, 1);
    chk("g_mem_blocked", bus.mem_req_ready, 0);
    for (int i = 0; i < 2; i++) begin
      edge_drive();
      sample();
      chk("g_mem_blocked", bus.mem_req_ready, 0);
    end
    edge_drive();
    bus.sram_rd_valid = 1'b1;
    bus.sram_rd_data  = 32'h0BADCAFE;
    sample();
    chk("g_mem_blocked", bus.mem_req_ready, 0);
    edge_drive();
    bus.sram_rd_valid = 1'b0;
    sample();
    chk("g_rsp",       bus.if_rsp_valid, 1);
    chk("g_rsp_data",  bus.if_rsp_data, 32'h0BADCAFE);
    chk("g_mem_ready", bus.mem_req_ready, 1);
    edge_drive();
    bus.mem_req_valid = 1'b0;
    sample();
    chk("g_wr_en",   bus.sram_wr_en, 1);
    chk("g_wr_addr", bus.sram_wr_addr, 32'h24);
    chk("g_wr_data", bus.sram_wr_data, 32'hCAFEF00D);
    chk("g_w_mask",  bus.sram_w_mask, 4'h6);
    chk("g_mem_rsp", bus.mem_rsp_valid, 0);
    edge_drive();

    // ---------------- randomized traffic vs transaction model ----------------
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ref_mem[i]  = $urandom;
      sram_mem[i] = ref_mem[i];
    end
    m_busy = 0; m_last_mem = 0; acc_if = 0; acc_mem = 0;
    exp_wr = 0; exp_rd = 0; exp_rsp_if = 0; exp_rsp_mem = 0;
    sram_cd = 0;
    for (int c = 0; c < RAND_CYCLES; c++) begin
      // SRAM side: scheduled read data, or a stray pulse while no read is outstanding
      bus.sram_rd_valid = 1'b0;
      if (sram_cd > 0) begin
        sram_cd--;
        if (sram_cd == 0) begin
          bus.sram_rd_valid = 1'b1;
          bus.sram_rd_data  = sram_mem[sram_idx];
        end
      end else if (!m_busy && $urandom_range(0, 7) == 0) begin
        bus.sram_rd_valid = 1'b1;
        bus.sram_rd_data  = $urandom;
      end
      if (acc_if)  bus.if_req_valid  = 1'b0;
      if (acc_mem) bus.mem_req_valid = 1'b0;
      if (!bus.if_req_valid && $urandom_range(0, 2) == 0) begin
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'($urandom_range(0, 7)) << 2;
      end
      if (!bus.mem_req_valid && $urandom_range(0, 2) == 0) begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we    = 1'($urandom_range(0, 1));
        bus.mem_req_addr  = 32'($urandom_range(0, 7)) << 2;
        bus.mem_req_wdata = $urandom;
        bus.mem_req_wmask = 4'($urandom_range(0, 15));
      end

      sample();
      g_if = 0; g_mem = 0;
      if (!m_busy) begin
        if (bus.if_req_valid && bus.mem_req_valid) begin
          g_if  = m_last_mem;
          g_mem = !m_last_mem;
        end else begin
          g_if  = bus.if_req_valid;
          g_mem = bus.mem_req_valid;
        end
      end
      chk("r_if_ready",  bus.if_req_ready,  g_if);
      chk("r_mem_ready", bus.mem_req_ready, g_mem);
      chk("r_wr_en", bus.sram_wr_en, exp_wr);
      if (exp_wr) begin
        chk("r_wr_addr", bus.sram_wr_addr, exp_wr_addr);
        chk("r_wr_data", bus.sram_wr_data, exp_wr_data);
        chk("r_w_mask",  bus.sram_w_mask,  exp_wr_mask);
      end
      chk("r_rd_en", bus.sram_rd_en, exp_rd);
      if (exp_rd) chk("r_rd_addr", bus.sram_rd_addr, exp_rd_addr);
      chk("r_if_rsp",  bus.if_rsp_valid,  exp_rsp_if);
      chk("r_mem_rsp", bus.mem_rsp_valid, exp_rsp_mem);
      if (exp_rsp_if || exp_rsp_mem) begin
        chk("r_rsp_data", exp_rsp_if ? bus.if_rsp_data : bus.mem_rsp_data, exp_rsp_data);
        chk("r_rsp_err",  exp_rsp_if ? bus.if_rsp_err  : bus.mem_rsp_err,  0);
      end

      // SRAM reacts to the strobes it sees
      if (bus.sram_wr_en)
        sram_mem[bus.sram_wr_addr[4:2]] = apply_mask(sram_mem[bus.sram_wr_addr[4:2]],
                                                     bus.sram_wr_data, bus.sram_w_mask);
      if (bus.sram_rd_en) begin
        sram_idx = bus.sram_rd_addr[4:2];
        sram_cd  = $urandom_range(1, 4);
      end

      // Model: what the next cycle must show
      exp_wr = 0; exp_rd = 0; exp_rsp_if = 0; exp_rsp_mem = 0;
      if (m_busy && bus.sram_rd_valid) begin
        m_busy       = 0;
        exp_rsp_mem  = rd_owner_mem;
        exp_rsp_if   = !rd_owner_mem;
        exp_rsp_data = rd_exp_data;
      end
      if (g_if || g_mem) begin
        m_last_mem = g_mem;
        if (g_mem && bus.mem_req_we) begin
          exp_wr      = 1;
          exp_wr_addr = bus.mem_req_addr;
          exp_wr_data = bus.mem_req_wdata;
          exp_wr_mask = bus.mem_req_wmask;
          ref_mem[exp_wr_addr[4:2]] = apply_mask(ref_mem[exp_wr_addr[4:2]], exp_wr_data, exp_wr_mask);
        end else begin
          exp_rd       = 1;
          exp_rd_addr  = g_mem ? bus.mem_req_addr : bus.if_req_addr;
          rd_owner_mem = g_mem;
          rd_exp_data  = ref_mem[exp_rd_addr[4:2]];
          m_busy       = 1;
        end
      end
      acc_if  = g_if;
      acc_mem = g_mem;
      edge_drive();
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
